// File: rtl/mb_sched_pkg.sv
// Shared types for the MB word-load scheduler: mux select encoding, FSM states
// and the MB word index.
package mb_sched_pkg;

    typedef logic [1:0] word_idx_t;

    typedef enum logic [2:0] {
        SEL_AR    = 3'b000,
        SEL_CACHE = 3'b001,
        SEL_MEM   = 3'b010,
        SEL_CHBUF = 3'b011,
        SEL_CCW   = 3'b100
    } mb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_FILL,
        ST_CH_XFER
    } sched_state_e;

    // Active-high load strobe for one MB word; hold lines are its complement.
    function automatic logic [3:0] word_onehot(word_idx_t w);
        return 4'b0001 << w;
    endfunction

endpackage

// File: rtl/ch_buf_adr_ctr.sv
// Loadable up/down channel-buffer address counter; wraps naturally at the ends
// of the ring. A load beats a step in the same cycle.
module ch_buf_adr_ctr #(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    input  logic         down_i,
    output logic [W-1:0] adr_o
);

    logic [W-1:0] adr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     adr_q <= '0;
        else if (load_i) adr_q <= load_val_i;
        else if (step_i) adr_q <= down_i ? adr_q - W'(1) : adr_q + W'(1);
    end

    assign adr_o = adr_q;

endmodule

// File: rtl/mb_load_sched.sv
// Per-cycle MB word-load scheduler: arbitrates memory fill, channel burst,
// cache writeback and EBOX store onto the MB mux and word hold lines.
module mb_load_sched
    import mb_sched_pkg::*;
#(
    parameter int MAX_CH_WORDS = 16,
    parameter int CH_ADR_W     = 7
) (
    input  logic                            clk_mbox_h,
    input  logic                            mr_reset_l,
    input  logic                            mem_data_valid_h,
    input  logic [1:0]                      mem_word_adr_h,
    input  logic                            mem_fill_start_h,
    input  logic                            nxm_any_l,
    input  logic                            ch_xfer_req_h,
    input  logic [$clog2(MAX_CH_WORDS)-1:0] ch_word_cnt_h,
    input  logic [1:0]                      ch_word_adr_h,
    input  logic                            ch_reverse_h,
    input  logic                            ch_adr_load_h,
    input  logic [CH_ADR_W-1:0]             ch_adr_val_h,
    input  logic                            cache_wb_req_h,
    input  logic [1:0]                      cache_wb_adr_h,
    input  logic                            ebox_st_req_h,
    input  logic [1:0]                      ebox_st_adr_h,
    output logic                            mb_in_sel_1_h,
    output logic                            mb_in_sel_2_h,
    output logic                            mb_in_sel_4_h,
    output logic                            mb_sel_hold_h,
    output logic                            mb0_hold_in_h,
    output logic                            mb1_hold_in_h,
    output logic                            mb2_hold_in_h,
    output logic                            mb3_hold_in_h,
    output logic [CH_ADR_W-1:0]             crc_ch_buf_adr_h,
    output logic                            crc_buf_mb_sel_h,
    output logic                            cache_wb_gnt_h,
    output logic                            ebox_st_gnt_h,
    output logic                            mem_fill_done_h,
    output logic                            ch_xfer_done_h,
    output logic                            busy_h
);

    localparam int CNT_W = $clog2(MAX_CH_WORDS);

    sched_state_e     state_q;
    mb_sel_e          sel_q;
    logic             sel_hold_q;
    logic [3:0]       hold_q;
    logic             chbuf_q, cgnt_q, egnt_q, fdone_q, cdone_q;
    logic [3:0]       mask_q;
    word_idx_t        ptr_q, pend_ptr_q;
    logic [CNT_W:0]   left_q;
    logic [CNT_W-1:0] pend_cnt_q;
    logic             pend_q;

    // Requester grants are masked while their previous grant is still showing.
    logic svc_blocked, cwb_elig, ebox_elig;
    assign svc_blocked = mem_fill_start_h | ch_xfer_req_h | pend_q;
    assign cwb_elig    = cache_wb_req_h & ~cgnt_q;
    assign ebox_elig   = ebox_st_req_h & ~egnt_q;

    always_ff @(posedge clk_mbox_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_AR;
            sel_hold_q <= 1'b1;
            hold_q     <= 4'hF;
            chbuf_q    <= 1'b0;
            cgnt_q     <= 1'b0;
            egnt_q     <= 1'b0;
            fdone_q    <= 1'b0;
            cdone_q    <= 1'b0;
            mask_q     <= '0;
            ptr_q      <= '0;
            left_q     <= '0;
            pend_q     <= 1'b0;
            pend_cnt_q <= '0;
            pend_ptr_q <= '0;
        end else begin
            sel_hold_q <= 1'b1;
            hold_q     <= 4'hF;
            chbuf_q    <= 1'b0;
            cgnt_q     <= 1'b0;
            egnt_q     <= 1'b0;
            fdone_q    <= 1'b0;
            cdone_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (mem_data_valid_h) begin
                        sel_q      <= SEL_MEM;
                        sel_hold_q <= 1'b0;
                        hold_q     <= ~word_onehot(mem_word_adr_h);
                    end else if (!svc_blocked && cwb_elig) begin
                        sel_q      <= SEL_CACHE;
                        sel_hold_q <= 1'b0;
                        hold_q     <= ~word_onehot(cache_wb_adr_h);
                        cgnt_q     <= 1'b1;
                    end else if (!svc_blocked && ebox_elig) begin
                        sel_q      <= SEL_AR;
                        sel_hold_q <= 1'b0;
                        hold_q     <= ~word_onehot(ebox_st_adr_h);
                        egnt_q     <= 1'b1;
                    end
                    if (mem_fill_start_h) begin
                        state_q <= ST_MEM_FILL;
                        mask_q  <= '0;
                        if (ch_xfer_req_h && !pend_q) begin
                            pend_q     <= 1'b1;
                            pend_cnt_q <= ch_word_cnt_h;
                            pend_ptr_q <= ch_word_adr_h;
                        end
                    end else if (pend_q) begin
                        state_q <= ST_CH_XFER;
                        left_q  <= {1'b0, pend_cnt_q} + (CNT_W+1)'(1);
                        ptr_q   <= pend_ptr_q;
                        pend_q  <= 1'b0;
                    end else if (ch_xfer_req_h) begin
                        state_q <= ST_CH_XFER;
                        left_q  <= {1'b0, ch_word_cnt_h} + (CNT_W+1)'(1);
                        ptr_q   <= ch_word_adr_h;
                    end
                end
                ST_MEM_FILL: begin
                    if (!nxm_any_l || mask_q == 4'hF) begin
                        fdone_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (mem_data_valid_h) begin
                        sel_q      <= SEL_MEM;
                        sel_hold_q <= 1'b0;
                        hold_q     <= ~word_onehot(mem_word_adr_h);
                        mask_q     <= mask_q | word_onehot(mem_word_adr_h);
                    end
                    if (ch_xfer_req_h && !pend_q) begin
                        pend_q     <= 1'b1;
                        pend_cnt_q <= ch_word_cnt_h;
                        pend_ptr_q <= ch_word_adr_h;
                    end
                end
                ST_CH_XFER: begin
                    if (left_q == '0) begin
                        cdone_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (mem_data_valid_h) begin
                        // memory return steals the cycle; channel stalls in place
                        sel_q      <= SEL_MEM;
                        sel_hold_q <= 1'b0;
                        hold_q     <= ~word_onehot(mem_word_adr_h);
                    end else begin
                        sel_q      <= SEL_CHBUF;
                        sel_hold_q <= 1'b0;
                        hold_q     <= ~word_onehot(ptr_q);
                        chbuf_q    <= 1'b1;
                        ptr_q      <= ptr_q + 2'd1;
                        left_q     <= left_q - (CNT_W+1)'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Address steps in the cycle its word is shown, so each word sees its own address.
    ch_buf_adr_ctr #(.W(CH_ADR_W)) u_adr_ctr (
        .clk_i      (clk_mbox_h),
        .rst_ni     (mr_reset_l),
        .load_i     (ch_adr_load_h),
        .load_val_i (ch_adr_val_h),
        .step_i     (chbuf_q),
        .down_i     (ch_reverse_h),
        .adr_o      (crc_ch_buf_adr_h)
    );

    assign mb_in_sel_1_h    = sel_q[0];
    assign mb_in_sel_2_h    = sel_q[1];
    assign mb_in_sel_4_h    = sel_q[2];
    assign mb_sel_hold_h    = sel_hold_q;
    assign mb0_hold_in_h    = hold_q[0];
    assign mb1_hold_in_h    = hold_q[1];
    assign mb2_hold_in_h    = hold_q[2];
    assign mb3_hold_in_h    = hold_q[3];
    assign crc_buf_mb_sel_h = chbuf_q;
    assign cache_wb_gnt_h   = cgnt_q;
    assign ebox_st_gnt_h    = egnt_q;
    assign mem_fill_done_h  = fdone_q;
    assign ch_xfer_done_h   = cdone_q;
    assign busy_h           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mb_load_sched.sv
// Scoreboard bench for mb_load_sched: stimulus tasks push expected MB loads and
// done pulses; a negedge monitor pops and compares whenever the DUT shows one.
module tb_mb_load_sched;

    logic       clk_mbox_h = 1'b0;
    logic       mr_reset_l = 1'b0;
    logic       mem_data_valid_h = 1'b0, mem_fill_start_h = 1'b0, nxm_any_l = 1'b1;
    logic [1:0] mem_word_adr_h = '0, ch_word_adr_h = '0, cache_wb_adr_h = '0, ebox_st_adr_h = '0;
    logic       ch_xfer_req_h = 1'b0, ch_reverse_h = 1'b0, ch_adr_load_h = 1'b0;
    logic [3:0] ch_word_cnt_h = '0;
    logic [6:0] ch_adr_val_h = '0;
    logic       cache_wb_req_h = 1'b0, ebox_st_req_h = 1'b0;
    logic       mb_in_sel_1_h, mb_in_sel_2_h, mb_in_sel_4_h, mb_sel_hold_h;
    logic       mb0_hold_in_h, mb1_hold_in_h, mb2_hold_in_h, mb3_hold_in_h;
    logic [6:0] crc_ch_buf_adr_h;
    logic       crc_buf_mb_sel_h, cache_wb_gnt_h, ebox_st_gnt_h;
    logic       mem_fill_done_h, ch_xfer_done_h, busy_h;

    mb_load_sched dut (
        .clk_mbox_h(clk_mbox_h), .mr_reset_l(mr_reset_l),
        .mem_data_valid_h(mem_data_valid_h), .mem_word_adr_h(mem_word_adr_h),
        .mem_fill_start_h(mem_fill_start_h), .nxm_any_l(nxm_any_l),
        .ch_xfer_req_h(ch_xfer_req_h), .ch_word_cnt_h(ch_word_cnt_h),
        .ch_word_adr_h(ch_word_adr_h), .ch_reverse_h(ch_reverse_h),
        .ch_adr_load_h(ch_adr_load_h), .ch_adr_val_h(ch_adr_val_h),
        .cache_wb_req_h(cache_wb_req_h), .cache_wb_adr_h(cache_wb_adr_h),
        .ebox_st_req_h(ebox_st_req_h), .ebox_st_adr_h(ebox_st_adr_h),
        .mb_in_sel_1_h(mb_in_sel_1_h), .mb_in_sel_2_h(mb_in_sel_2_h),
        .mb_in_sel_4_h(mb_in_sel_4_h), .mb_sel_hold_h(mb_sel_hold_h),
        .mb0_hold_in_h(mb0_hold_in_h), .mb1_hold_in_h(mb1_hold_in_h),
        .mb2_hold_in_h(mb2_hold_in_h), .mb3_hold_in_h(mb3_hold_in_h),
        .crc_ch_buf_adr_h(crc_ch_buf_adr_h), .crc_buf_mb_sel_h(crc_buf_mb_sel_h),
        .cache_wb_gnt_h(cache_wb_gnt_h), .ebox_st_gnt_h(ebox_st_gnt_h),
        .mem_fill_done_h(mem_fill_done_h), .ch_xfer_done_h(ch_xfer_done_h),
        .busy_h(busy_h)
    );

    always #5 clk_mbox_h = ~clk_mbox_h;

    localparam int S_AR = 0, S_CACHE = 1, S_MEM = 2, S_CHBUF = 3;

    typedef struct {
        int sel; int word; int chbuf; int cg; int eg; int adr; bit gap1; int txn;
    } ld_t;
    typedef struct {
        int is_ch; bit gap1; int txn;
    } dn_t;

    ld_t ldq[$];
    dn_t dnq[$];
    int  txn_id = 0;
    int  m_adr  = 0;
    bit  rst_chk = 0, stim_done = 0;

    int  total = 0, bad = 0;
    int  cyc = 0, last_ld = -10, last_ld_txn = -1;

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk_mbox_h) begin
        logic [3:0] holds;
        int nlow, w, sel;
        ld_t e;
        dn_t d;
        cyc++;
        holds = {mb3_hold_in_h, mb2_hold_in_h, mb1_hold_in_h, mb0_hold_in_h};
        sel   = int'({mb_in_sel_4_h, mb_in_sel_2_h, mb_in_sel_1_h});
        if (mr_reset_l) begin
            if (rst_chk) begin
                chk("rst_holds", int'(holds), 15);
                chk("rst_sel", sel, 0);
                chk("rst_sel_hold", int'(mb_sel_hold_h), 1);
                chk("rst_adr", int'(crc_ch_buf_adr_h), 0);
                chk("rst_busy", int'(busy_h), 0);
                chk("rst_pulses", int'({cache_wb_gnt_h, ebox_st_gnt_h, mem_fill_done_h, ch_xfer_done_h}), 0);
            end
            nlow = 4 - $countones(holds);
            chk("one_hold_low", int'(nlow <= 1), 1);
            chk("sel_hold_iff_idle", int'(mb_sel_hold_h), int'(nlow == 0));
            if (nlow == 1) begin
                w = 0;
                for (int i = 0; i < 4; i++) if (!holds[i]) w = i;
                if (ldq.size() == 0) begin
                    chk("unexpected_load_word", w, -1);
                end else begin
                    e = ldq.pop_front();
                    chk("ld_sel", sel, e.sel);
                    chk("ld_word", w, e.word);
                    chk("ld_chbuf", int'(crc_buf_mb_sel_h), e.chbuf);
                    chk("ld_cache_gnt", int'(cache_wb_gnt_h), e.cg);
                    chk("ld_ebox_gnt", int'(ebox_st_gnt_h), e.eg);
                    if (e.chbuf != 0) chk("ld_ch_adr", int'(crc_ch_buf_adr_h), e.adr);
                    if (e.gap1) chk("ld_back_to_back", cyc - last_ld, 1);
                    if (dnq.size() > 0) chk("ld_after_prev_done", int'(dnq[0].txn >= e.txn), 1);
                    last_ld_txn = e.txn;
                end
                last_ld = cyc;
            end else begin
                chk("idle_no_gnt_chbuf", int'({cache_wb_gnt_h, ebox_st_gnt_h, crc_buf_mb_sel_h}), 0);
            end
            if (mem_fill_done_h || ch_xfer_done_h) begin
                chk("single_done", int'(mem_fill_done_h & ch_xfer_done_h), 0);
                if (dnq.size() == 0) begin
                    chk("unexpected_done_is_ch", int'(ch_xfer_done_h), -1);
                end else begin
                    d = dnq.pop_front();
                    chk("done_kind_is_ch", int'(ch_xfer_done_h), d.is_ch);
                    if (d.gap1) chk("done_gap", cyc - last_ld, 1);
                    if (ldq.size() > 0) chk("done_after_loads", int'(ldq[0].txn > d.txn), 1);
                end
            end
        end
        if (stim_done) begin
            chk("leftover_loads", ldq.size(), 0);
            chk("leftover_dones", dnq.size(), 0);
            chk("end_busy", int'(busy_h), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (cyc > 60000) begin
            chk("watchdog_cycles", cyc, 60000);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    // ---------------- reference model + stimulus ----------------
    task automatic tick();
        @(negedge clk_mbox_h);
    endtask

    task automatic push_ld(int sel, int word, int chbuf, int cg, int eg, int adr, bit gap1, int txn);
        ld_t e;
        e.sel = sel; e.word = word; e.chbuf = chbuf; e.cg = cg; e.eg = eg;
        e.adr = adr; e.gap1 = gap1; e.txn = txn;
        ldq.push_back(e);
    endtask

    task automatic push_dn(int is_ch, bit gap1, int txn);
        dn_t d;
        d.is_ch = is_ch; d.gap1 = gap1; d.txn = txn;
        dnq.push_back(d);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy_h; i++) tick();
        repeat (2) tick();
    endtask

    // Channel words in the model: each gets the current ring address, then the
    // pointer advances mod 4 and the address moves by +/-1 mod 128.
    task automatic model_ch_word(int txn, ref int p, input int rev, input bit gap1);
        push_ld(S_CHBUF, p, 1, 0, 0, m_adr, gap1, txn);
        p = (p + 1) % 4;
        m_adr = rev ? (m_adr + 127) % 128 : (m_adr + 1) % 128;
    endtask

    task automatic do_fill(int words[$], bit abort, bit valid_at_abort,
                           bit with_ch, int cnt, int cword);
        int t, p;
        txn_id++; t = txn_id;
        mem_fill_start_h = 1'b1;
        if (with_ch) begin
            ch_xfer_req_h = 1'b1; ch_word_cnt_h = 4'(cnt); ch_word_adr_h = 2'(cword);
        end
        tick();
        mem_fill_start_h = 1'b0; ch_xfer_req_h = 1'b0;
        foreach (words[i]) begin
            mem_data_valid_h = 1'b1; mem_word_adr_h = 2'(words[i]);
            push_ld(S_MEM, words[i], 0, 0, 0, 0, i > 0, t);
            tick();
        end
        mem_data_valid_h = 1'b0;
        if (abort) begin
            nxm_any_l = 1'b0;
            mem_data_valid_h = valid_at_abort; mem_word_adr_h = 2'($urandom_range(0, 3));
            tick();
            nxm_any_l = 1'b1; mem_data_valid_h = 1'b0;
        end
        push_dn(0, words.size() > 0, t);
        if (with_ch) begin
            txn_id++; p = cword;
            for (int i = 0; i <= cnt; i++) model_ch_word(txn_id, p, int'(ch_reverse_h), i > 0);
            push_dn(1, 1'b1, txn_id);
            wait_idle();
        end
        wait_idle();
    endtask

    task automatic do_chan(bit load, int adr, int rev, int cnt, int word, int max_stall);
        int t, p, n, stalls;
        bit first;
        txn_id++; t = txn_id;
        if (load) begin
            ch_adr_load_h = 1'b1; ch_adr_val_h = 7'(adr);
            tick();
            ch_adr_load_h = 1'b0; m_adr = adr;
        end
        ch_reverse_h = 1'(rev);
        ch_xfer_req_h = 1'b1; ch_word_cnt_h = 4'(cnt); ch_word_adr_h = 2'(word);
        tick();
        ch_xfer_req_h = 1'b0;
        n = cnt + 1; p = word; stalls = 0; first = 1'b1;
        while (n > 0) begin
            if (stalls < max_stall && $urandom_range(0, 3) == 0) begin
                mem_data_valid_h = 1'b1; mem_word_adr_h = 2'($urandom_range(0, 3));
                push_ld(S_MEM, int'(mem_word_adr_h), 0, 0, 0, 0, !first, t);
                stalls++;
            end else begin
                model_ch_word(t, p, rev, !first);
                n--;
            end
            first = 1'b0;
            tick();
            mem_data_valid_h = 1'b0;
        end
        push_dn(1, 1'b1, t);
        wait_idle();
    endtask

    task automatic do_req(bit c, bit e, int wc, int we, bit stray);
        int t, sw;
        bit first;
        txn_id++; t = txn_id; first = 1'b1;
        if (stray) begin
            sw = $urandom_range(0, 3);
            mem_data_valid_h = 1'b1; mem_word_adr_h = 2'(sw);
            push_ld(S_MEM, sw, 0, 0, 0, 0, 1'b0, t);
            first = 1'b0;
        end
        if (c) begin push_ld(S_CACHE, wc, 0, 1, 0, 0, !first, t); first = 1'b0; end
        if (e) push_ld(S_AR, we, 0, 0, 1, 0, !first, t);
        cache_wb_req_h = c; cache_wb_adr_h = 2'(wc);
        ebox_st_req_h  = e; ebox_st_adr_h  = 2'(we);
        for (int i = 0; i < 20 && (cache_wb_req_h || ebox_st_req_h); i++) begin
            tick();
            mem_data_valid_h = 1'b0;
            if (cache_wb_gnt_h) cache_wb_req_h = 1'b0;
            if (ebox_st_gnt_h)  ebox_st_req_h  = 1'b0;
        end
        cache_wb_req_h = 1'b0; ebox_st_req_h = 1'b0; mem_data_valid_h = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int ws[$];
        int x, kind;
        bit [3:0] seen;
        repeat (3) tick();
        mr_reset_l = 1'b1;
        rst_chk = 1'b1;
        repeat (5) tick();
        rst_chk = 1'b0;

        ws = '{2, 0, 3, 1};
        do_fill(ws, 0, 0, 0, 0, 0);
        do_chan(1, 126, 0, 3, 3, 0);
        do_chan(1, 1, 1, 2, 0, 0);
        do_req(1, 1, 2, 1, 0);
        ws = '{0, 1};
        do_fill(ws, 1, 1, 0, 0, 0);
        ch_reverse_h = 1'b0;
        ws = '{3, 3, 1, 0, 2};
        do_fill(ws, 0, 0, 1, 2, 1);
        do_req(1, 0, 3, 0, 1);
        do_chan(1, 0, 1, 15, 2, 3);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                ws.delete();
                if ($urandom_range(0, 3) == 0) begin
                    x = $urandom_range(0, 3);
                    for (int k = 0; k < $urandom_range(1, 3); k++)
                        ws.push_back((x + 1 + $urandom_range(0, 2)) % 4);
                    do_fill(ws, 1, 1'($urandom_range(0, 1)), 0, 0, 0);
                end else begin
                    seen = '0;
                    while (seen != 4'hF) begin
                        x = $urandom_range(0, 3);
                        ws.push_back(x);
                        seen[x] = 1'b1;
                    end
                    do_fill(ws, 0, 0, 0, 0, 0);
                end
            end else if (kind == 1) begin
                do_chan(1'($urandom_range(0, 1)), $urandom_range(0, 127), $urandom_range(0, 1),
                        $urandom_range(0, 15), $urandom_range(0, 3), 3);
            end else begin
                x = $urandom_range(1, 3);
                do_req(x[0], x[1], $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)));
            end
        end
        repeat (3) tick();
        stim_done = 1'b1;
    end

endmodule
